// File: rtl/delay_stats.sv
// Delay statistics: accumulates N=2^LOG2N samples, then latches avg/var/min/max.
// Variance path is built only when DELAY_STATS_VAR_EN is defined.
module delay_stats #(
  parameter int W     = 16,
  parameter int LOG2N = 10
) (
  input  logic             clk16M,
  input  logic             rstbt,
  input  logic             start,
  input  logic             cont,
  input  logic [W-1:0]     sample,
  input  logic             sample_valid,
  input  logic [1:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     result,
  output logic             var_ovf,
  output logic [LOG2N:0]   count
);

  localparam int SW = W + LOG2N;
  localparam int W2 = 2 * W;
  localparam logic [LOG2N:0] LAST = (LOG2N+1)'((1 << LOG2N) - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, CALC, DONE} state_t;

  state_t          state_q;
  logic            busy_q, done_q;
  logic [SW-1:0]   sum_q, sum_d;
  logic [LOG2N:0]  cnt_q, cnt_d;
  logic [W-1:0]    min_q, min_d, max_q, max_d;
  logic [W-1:0]    avg_l_q, min_l_q, max_l_q, result_q, result_d;
  logic [W-1:0]    var_val;
  logic            ovf_val;
  logic            clr, acc;

  assign clr = start ? (state_q != CALC) : (state_q == DONE && cont);
  assign acc = (state_q == ACCUM) && sample_valid && !start;

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    min_d = min_q;
    max_d = max_q;
    if (clr) begin
      sum_d = '0;
      cnt_d = '0;
      min_d = '1;
      max_d = '0;
    end else if (acc) begin
      sum_d = sum_q + SW'(sample);
      cnt_d = cnt_q + 1'b1;
      min_d = (sample < min_q) ? sample : min_q;
      max_d = (sample > max_q) ? sample : max_q;
    end
  end

`ifdef DELAY_STATS_VAR_EN
  logic [W2+LOG2N-1:0] sqsum_q, sqsum_d;
  logic [2*SW-1:0]     sum_sq;
  logic [W2-1:0]       sample_sq, v;
  logic [W-1:0]        var_l_q, var_calc;
  logic                ovf_l_q, ovf_calc;

  always_comb begin
    sample_sq = W2'(sample) * W2'(sample);
    sqsum_d   = sqsum_q;
    if (clr)      sqsum_d = '0;
    else if (acc) sqsum_d = sqsum_q + (W2+LOG2N)'(sample_sq);
    sum_sq    = (2*SW)'(sum_q) * (2*SW)'(sum_q);
    v         = W2'(sqsum_q >> LOG2N) - W2'(sum_sq >> (2*LOG2N));
    ovf_calc  = |v[W2-1:W];
    var_calc  = ovf_calc ? '1 : v[W-1:0];
  end

  always_ff @(posedge clk16M) begin
    if (rstbt) begin
      sqsum_q <= '0;
      var_l_q <= '0;
      ovf_l_q <= 1'b0;
    end else begin
      sqsum_q <= sqsum_d;
      if (state_q == CALC) begin
        var_l_q <= var_calc;
        ovf_l_q <= ovf_calc;
      end
    end
  end

  assign var_val = var_l_q;
  assign ovf_val = ovf_l_q;
`else
  assign var_val = '0;
  assign ovf_val = 1'b0;
`endif

  always_comb begin
    case (sel)
      2'd0:    result_d = avg_l_q;
      2'd1:    result_d = var_val;
      2'd2:    result_d = min_l_q;
      default: result_d = max_l_q;
    endcase
  end

  always_ff @(posedge clk16M) begin
    if (rstbt) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= ACCUM;
          busy_q  <= 1'b1;
        end
        ACCUM: if (acc && cnt_q == LAST) state_q <= CALC;
        CALC: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          done_q <= 1'b0;
          if (cont || start) begin
            state_q <= ACCUM;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  // Latched stats survive restarts; only the CALC->DONE edge or reset touches them.
  always_ff @(posedge clk16M) begin
    if (rstbt) begin
      sum_q    <= '0;
      cnt_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      avg_l_q  <= '0;
      min_l_q  <= '0;
      max_l_q  <= '0;
      result_q <= '0;
    end else begin
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      min_q    <= min_d;
      max_q    <= max_d;
      result_q <= result_d;
      if (state_q == CALC) begin
        avg_l_q <= W'(sum_q >> LOG2N);
        min_l_q <= min_q;
        max_l_q <= max_q;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign var_ovf = ovf_val;
  assign count   = cnt_q;

endmodule

// File: tb/tb_delay_stats.sv
// Directed bench for delay_stats at W=16, LOG2N=2 (N=4).
module tb_delay_stats;

  localparam int W = 16;
  localparam int LOG2N = 2;
`ifdef DELAY_STATS_VAR_EN
  localparam bit VAR_ON = 1'b1;
`else
  localparam bit VAR_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstbt = 1'b1;
  logic             start = 1'b0;
  logic             cont = 1'b0;
  logic [W-1:0]     sample = '0;
  logic             sample_valid = 1'b0;
  logic [1:0]       sel = 2'd0;
  logic             busy, done, var_ovf;
  logic [W-1:0]     result;
  logic [LOG2N:0]   count;

  delay_stats #(.W(W), .LOG2N(LOG2N)) dut (
    .clk16M(clk), .rstbt(rstbt), .start(start), .cont(cont),
    .sample(sample), .sample_valid(sample_valid), .sel(sel),
    .busy(busy), .done(done), .result(result), .var_ovf(var_ovf), .count(count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int done_seen = 0;

  always @(negedge clk) if (done) done_seen++;

  typedef struct {
    logic [W-1:0] s0, s1, s2, s3;
    logic [W-1:0] avg, vr, mn, mx;
    logic         ovf;
  } vec_t;

  vec_t tbl[6];

  function automatic vec_t mk(input logic [W-1:0] a, b, c, d, av, vr, mn, mx, input logic ovf);
    vec_t t;
    t.s0 = a; t.s1 = b; t.s2 = c; t.s3 = d;
    t.avg = av; t.vr = vr; t.mn = mn; t.mx = mx; t.ovf = ovf;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic feed(input logic [W-1:0] x);
    sample = x;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 10; k++) begin
      if (done) break;
      tick();
    end
    if (k == 10) chk({nm, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic chk_sel(input string nm, input logic [1:0] s, input logic [W-1:0] exp);
    sel = s;
    tick();
    chk(nm, 32'(result), 32'(exp));
  endtask

  initial begin
    int d0;
    tbl[0] = mk(16'd10, 16'd20, 16'd30, 16'd40, 16'd25, 16'd125, 16'd10, 16'd40, 1'b0);
    tbl[1] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 16'hFFFF, 16'hFFFF, 1'b0);
    tbl[2] = mk(16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'd0, 16'hFFFF, 1'b1);
    tbl[3] = mk(16'd1, 16'd2, 16'd3, 16'd4, 16'd2, 16'd1, 16'd1, 16'd4, 1'b0);
    tbl[4] = mk(16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd0, 16'd7, 16'd7, 1'b0);
    tbl[5] = mk(16'd100, 16'd3, 16'd250, 16'd9, 16'd90, 16'd9957, 16'd3, 16'd250, 1'b0);

    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ovf", 32'(var_ovf), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rstbt = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      d0 = done_seen;
      pulse_start();
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d_count0", i), 32'(count), 32'd0);
      feed(tbl[i].s0);
      feed(tbl[i].s1);
      feed(tbl[i].s2);
      feed(tbl[i].s3);
      wait_done($sformatf("v%0d", i));
      chk($sformatf("v%0d_countN", i), 32'(count), 32'd4);
      tick();
      chk($sformatf("v%0d_ovf", i), 32'(var_ovf), 32'(VAR_ON ? tbl[i].ovf : 1'b0));
      chk_sel($sformatf("v%0d_avg", i), 2'd0, tbl[i].avg);
      chk_sel($sformatf("v%0d_var", i), 2'd1, VAR_ON ? tbl[i].vr : 16'd0);
      chk_sel($sformatf("v%0d_min", i), 2'd2, tbl[i].mn);
      chk_sel($sformatf("v%0d_max", i), 2'd3, tbl[i].mx);
      chk($sformatf("v%0d_ndone", i), 32'(done_seen - d0), 32'd1);
    end

    // Restart mid-run with a valid sample that must be dropped.
    d0 = done_seen;
    pulse_start();
    feed(16'd5);
    feed(16'd6);
    start = 1'b1; sample = 16'd99; sample_valid = 1'b1;
    tick();
    start = 1'b0; sample_valid = 1'b0;
    chk("rs_count0", 32'(count), 32'd0);
    feed(16'd1); feed(16'd2); feed(16'd3); feed(16'd4);
    wait_done("rs");
    tick();
    chk_sel("rs_avg", 2'd0, 16'd2);
    chk_sel("rs_min", 2'd2, 16'd1);
    chk_sel("rs_max", 2'd3, 16'd4);
    chk("rs_ndone", 32'(done_seen - d0), 32'd1);

    // Continuous mode: two back-to-back runs.
    d0 = done_seen;
    cont = 1'b1;
    pulse_start();
    feed(16'd1); feed(16'd2); feed(16'd3); feed(16'd4);
    wait_done("c1");
    tick();
    chk("c1_busy", 32'(busy), 32'd1);
    chk("c1_count0", 32'(count), 32'd0);
    feed(16'd5); feed(16'd6); feed(16'd7); feed(16'd8);
    wait_done("c2");
    tick();
    chk("c2_busy", 32'(busy), 32'd1);
    chk_sel("c2_avg", 2'd0, 16'd6);
    chk_sel("c2_min", 2'd2, 16'd5);
    chk_sel("c2_max", 2'd3, 16'd8);
    chk("c2_ndone", 32'(done_seen - d0), 32'd2);
    cont = 1'b0;

    // Reset mid-run: aborts with no done pulse and clears everything.
    rstbt = 1'b1;
    tick();
    rstbt = 1'b0;
    sel = 2'd0;
    pulse_start();
    feed(16'd11);
    feed(16'd12);
    d0 = done_seen;
    rstbt = 1'b1; start = 1'b1; sample = 16'd13; sample_valid = 1'b1;
    tick();
    rstbt = 1'b0; start = 1'b0; sample_valid = 1'b0;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_result", 32'(result), 32'd0);
    chk("ar_ovf", 32'(var_ovf), 32'd0);
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("ar_nodone", 32'(done_seen - d0), 32'd0);
    chk_sel("ar_max_clr", 2'd3, 16'd0);
    chk("ar_busy_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/delay_stats.md
DELAY_STATS -- requirements
Module: delay_stats

Interface
REQ-001 Parameter W, default 16: sample width in bits.
REQ-002 Parameter LOG2N, default 10: log2 of samples per run, so N = 2^LOG2N.
REQ-003 clk16M  input  1  sole clock; all logic on the rising edge.
REQ-004 rstbt  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that clears the accumulators and begins a run.
REQ-006 cont  input  1  continuous mode: 1 = rearm automatically after each run.
REQ-007 sample  input  W  delay sample, qualified by sample_valid.
REQ-008 sample_valid  input  1  sample present this cycle.
REQ-009 sel  input  2  result select: 0 avg, 1 var, 2 min, 3 max.
REQ-010 busy  output  1  high in ACCUM and CALC.
REQ-011 done  output  1  one-cycle pulse when results update.
REQ-012 result  output  W  registered selected statistic.
REQ-013 var_ovf  output  1  latched variance does not fit in W bits.
REQ-014 count  output  LOG2N+1  samples accepted in the current run.

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM, CALC and DONE; reset state is IDLE.
REQ-016 IDLE: start moves to ACCUM and, in the same edge, clears sum, sqsum and count, sets min to all-ones and max to 0.
REQ-017 ACCUM, sample_valid=1, start=0: the block SHALL update sum += sample, sqsum += sample^2, count += 1, min/max by unsigned compare.
REQ-018 ACCUM: the edge that accepts sample N SHALL move to CALC; no further samples are accepted in that run.
REQ-019 Samples SHALL be ignored in IDLE, CALC and DONE.
REQ-020 start in ACCUM SHALL restart the run with the REQ-016 clears; if sample_valid is high in that cycle the sample is discarded.
REQ-021 Accumulator widths SHALL be: sum W+LOG2N bits, sqsum 2W+LOG2N bits; neither may wrap.
REQ-022 CALC, one cycle: avg = sum >> LOG2N; v = (sqsum >> LOG2N) - ((sum*sum) >> 2*LOG2N), computed at 2W bits.
REQ-023 CALC results and min/max SHALL be latched into result registers on the CALC->DONE edge.
REQ-024 If v[2W-1:W] is nonzero, the latched variance SHALL be all-ones and var_ovf SHALL be set; otherwise var = v[W-1:0] and var_ovf is cleared.
REQ-025 DONE, one cycle: done=1. It SHALL go to ACCUM with the REQ-016 clears if cont=1 or start=1, else to IDLE.
REQ-026 result SHALL register the statistic chosen by sel one cycle after the sel change or after the latch.
REQ-027 Latched statistics SHALL hold until the next DONE; a restart SHALL NOT clear them.
REQ-028 count SHALL read N during CALC and DONE and 0 after a clear.

Reset
REQ-029 rstbt SHALL force IDLE and zero busy, done, result, var_ovf, count, all accumulators and latched statistics; it overrides start and sample_valid in the same cycle.
REQ-030 rstbt asserted mid-run SHALL abort the run without a done pulse.

Configuration
REQ-031 With macro DELAY_STATS_VAR_EN defined: sqsum, the variance path and var_ovf are implemented as specified above.
REQ-032 Without DELAY_STATS_VAR_EN: no sqsum or multiplier is built, sel=1 returns 0 and var_ovf is tied to 0; all other behaviour is unchanged.

Verification (W=16, LOG2N=2, DELAY_STATS_VAR_EN defined unless stated)
REQ-033 start; samples 10,20,30,40 -> done pulse; avg 25, var 125, min 10, max 40, var_ovf 0.
REQ-034 Samples 0xFFFF x4 -> avg 0xFFFF, var 0, min = max = 0xFFFF; confirms no accumulator wrap.
REQ-035 Samples 0,0,0xFFFF,0xFFFF -> v = 0x3FFF8000, var_ovf 1, var result 0xFFFF, avg 0x7FFF.
REQ-036 Samples 5,6, then start with sample_valid=1 carrying 99, then 1,2,3,4 -> avg 2, min 1, max 4, exactly one done pulse.
REQ-037 cont=1, 8 valid samples 1..8 -> two done pulses; second gives avg 6, min 5, max 8; busy returns high after each DONE.
REQ-038 rstbt after 2 samples in ACCUM -> next cycle busy 0, count 0, result 0, no done pulse; rebuild without the macro -> sel=1 returns 0.
